// File: rtl/lcd_page_arbiter_if.sv
// Page-request, frame-content and backlight signals between the LCD page sources,
// the page arbiter and the LCD driver.
interface lcd_page_arbiter_if;
    logic [2:0]   req;
    logic [255:0] frame0;
    logic [255:0] frame1;
    logic [255:0] frame2;
    logic         frame_done;
    logic         bl_in;
    logic [255:0] data_out;
    logic [2:0]   grant;
    logic         bl_out;

    modport master (
        output req, frame0, frame1, frame2, frame_done, bl_in,
        input  data_out, grant, bl_out
    );

    modport slave (
        input  req, frame0, frame1, frame2, frame_done, bl_in,
        output data_out, grant, bl_out
    );
endinterface

// File: rtl/lcd_page_arbiter.sv
// Chooses which of three 32-character pages the LCD shows, holding each page for a dwell
// time unless preempted. Optional backlight blink on the alarm page: macro LCD_ARB_BLINK_EN.
module lcd_page_arbiter #(
    parameter int DWELL_FRAMES = 8,
    parameter int BLINK_FRAMES = 16
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    lcd_page_arbiter_if.slave bus
);

    localparam int               DW_W       = $clog2(DWELL_FRAMES) + 1;
    localparam logic [DW_W-1:0]  DWELL_MAX  = DW_W'(DWELL_FRAMES - 1);
    localparam logic [DW_W-1:0]  DWELL_ONE  = DW_W'(1);
    localparam logic [DW_W-1:0]  DWELL_ZERO = DW_W'(0);
    localparam logic [1:0]       ST_HOLD    = 2'd0;
    localparam logic [1:0]       ST_FREE    = 2'd1;
    localparam logic [1:0]       ST_SWAP    = 2'd2;
    localparam logic [255:0]     BLANK      = {32{8'h20}};

    if (DWELL_FRAMES < 1 || BLINK_FRAMES < 1) begin : g_param_check
        $error("lcd_page_arbiter: DWELL_FRAMES and BLINK_FRAMES must be at least 1");
    end

    function automatic logic [2:0] src_onehot(input logic [1:0] src);
        case (src)
            2'd1:    src_onehot = 3'b010;
            2'd2:    src_onehot = 3'b100;
            default: src_onehot = 3'b001;
        endcase
    endfunction

    function automatic logic [1:0] top_src(input logic [2:0] elig);
        if (elig[2]) begin
            top_src = 2'd2;
        end else if (elig[1]) begin
            top_src = 2'd1;
        end else begin
            top_src = 2'd0;
        end
    endfunction

    function automatic logic [255:0] pick_frame(input logic [1:0] src, input logic [255:0] f0,
                                                input logic [255:0] f1, input logic [255:0] f2);
        case (src)
            2'd1:    pick_frame = f1;
            2'd2:    pick_frame = f2;
            default: pick_frame = f0;
        endcase
    endfunction

    logic [1:0]      state_r;
    logic [1:0]      owner_r;
    logic [1:0]      pending_r;
    logic [DW_W-1:0] dwell_r;
    logic [255:0]    data_out_r;
    logic [2:0]      grant_r;
    logic            bl_out_r;

    logic [2:0]      elig_s;
    logic [1:0]      top_s;
    logic [1:0]      swap_pend_s;
    logic [DW_W-1:0] dwell_inc_s;
    logic [255:0]    owner_frame_s;
    logic [255:0]    pend_frame_s;
    logic [1:0]      state_nx_s;
    logic [1:0]      owner_nx_s;
    logic [1:0]      pending_nx_s;
    logic [DW_W-1:0] dwell_nx_s;
    logic [255:0]    data_nx_s;

    // Source 0 is always eligible; pending follows the highest requester while a switch waits.
    always_comb begin
        elig_s        = bus.req | 3'b001;
        top_s         = top_src(elig_s);
        dwell_inc_s   = (dwell_r == DWELL_MAX) ? dwell_r : (dwell_r + DWELL_ONE);
        owner_frame_s = pick_frame(owner_r, bus.frame0, bus.frame1, bus.frame2);
        if ((top_s > pending_r) || !elig_s[pending_r]) begin
            swap_pend_s = top_s;
        end else begin
            swap_pend_s = pending_r;
        end
        pend_frame_s  = pick_frame(swap_pend_s, bus.frame0, bus.frame1, bus.frame2);
    end

    // Next-state logic for the HOLD / FREE / SWAP arbiter.
    always_comb begin
        state_nx_s   = state_r;
        owner_nx_s   = owner_r;
        pending_nx_s = pending_r;
        dwell_nx_s   = dwell_r;
        data_nx_s    = data_out_r;
        case (state_r)
            ST_HOLD: begin
                if (bus.frame_done) begin
                    dwell_nx_s = dwell_inc_s;
                    data_nx_s  = owner_frame_s;
                end else begin
                    dwell_nx_s = dwell_r;
                end
                if (top_s > owner_r) begin
                    state_nx_s   = ST_SWAP;
                    pending_nx_s = top_s;
                end else if (bus.frame_done && (dwell_inc_s == DWELL_MAX)) begin
                    state_nx_s = ST_FREE;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            ST_FREE: begin
                if (bus.frame_done) begin
                    data_nx_s = owner_frame_s;
                end else begin
                    data_nx_s = data_out_r;
                end
                if (top_s != owner_r) begin
                    state_nx_s   = ST_SWAP;
                    pending_nx_s = top_s;
                end else begin
                    state_nx_s = ST_FREE;
                end
            end
            ST_SWAP: begin
                pending_nx_s = swap_pend_s;
                if (swap_pend_s == owner_r) begin
                    // Switch cancelled: keep owner and dwell, only refresh the snapshot.
                    state_nx_s = ST_FREE;
                    if (bus.frame_done) begin
                        data_nx_s = owner_frame_s;
                    end else begin
                        data_nx_s = data_out_r;
                    end
                end else if (bus.frame_done) begin
                    state_nx_s = ST_HOLD;
                    owner_nx_s = swap_pend_s;
                    data_nx_s  = pend_frame_s;
                    dwell_nx_s = DWELL_ZERO;
                end else begin
                    state_nx_s = ST_SWAP;
                end
            end
            default: begin
                state_nx_s   = ST_FREE;
                owner_nx_s   = 2'd0;
                pending_nx_s = 2'd0;
                dwell_nx_s   = DWELL_ZERO;
            end
        endcase
    end

    // Arbiter state and registered page outputs.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_r    <= ST_FREE;
            owner_r    <= 2'd0;
            pending_r  <= 2'd0;
            dwell_r    <= DWELL_ZERO;
            data_out_r <= BLANK;
            grant_r    <= 3'b001;
        end else begin
            state_r    <= state_nx_s;
            owner_r    <= owner_nx_s;
            pending_r  <= pending_nx_s;
            dwell_r    <= dwell_nx_s;
            data_out_r <= data_nx_s;
            grant_r    <= src_onehot(owner_nx_s);
        end
    end

`ifdef LCD_ARB_BLINK_EN
    localparam int              BK_W      = $clog2(BLINK_FRAMES) + 1;
    localparam logic [BK_W-1:0] BLINK_MAX = BK_W'(BLINK_FRAMES - 1);
    localparam logic [BK_W-1:0] BLINK_ONE = BK_W'(1);

    logic [BK_W-1:0] blink_cnt_r;

    // Backlight: blinks while the alarm page owns the display, otherwise follows bl_in.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            blink_cnt_r <= {BK_W{1'b0}};
            bl_out_r    <= 1'b0;
        end else if ((owner_nx_s == 2'd2) && (owner_r != 2'd2)) begin
            blink_cnt_r <= {BK_W{1'b0}};
            bl_out_r    <= 1'b1;
        end else if (owner_r == 2'd2) begin
            if (bus.frame_done && (blink_cnt_r == BLINK_MAX)) begin
                blink_cnt_r <= {BK_W{1'b0}};
                bl_out_r    <= ~bl_out_r;
            end else if (bus.frame_done) begin
                blink_cnt_r <= blink_cnt_r + BLINK_ONE;
                bl_out_r    <= bl_out_r;
            end else begin
                blink_cnt_r <= blink_cnt_r;
                bl_out_r    <= bl_out_r;
            end
        end else begin
            blink_cnt_r <= blink_cnt_r;
            bl_out_r    <= bus.bl_in;
        end
    end
`else
    // Backlight passes through with one cycle of latency.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            bl_out_r <= 1'b0;
        end else begin
            bl_out_r <= bus.bl_in;
        end
    end
`endif

    assign bus.data_out = data_out_r;
    assign bus.grant    = grant_r;
    assign bus.bl_out   = bl_out_r;

endmodule

// File: tb/tb_lcd_page_arbiter.sv
// Directed bench for lcd_page_arbiter: a cycle-by-cycle vector table plus hand-written
// sequences for preemption, cancelled switches, coincident pulses and reset mid-switch.
module tb_lcd_page_arbiter;

    logic CLOCK_50 = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    lcd_page_arbiter_if bus();

    lcd_page_arbiter #(.DWELL_FRAMES(8), .BLINK_FRAMES(16)) dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic       rst;
        logic [2:0] req;
        logic       fd;
        logic       bl;
        logic [2:0] exp_grant;
        logic [1:0] exp_src;    // 0..2 = frame0..2, 3 = blank
        logic       exp_bl;
    } vec_t;

    localparam int NV = 31;
    vec_t tv [NV];

    logic [255:0] f0, f1, f2, f2_alt, blank;

    function automatic logic [255:0] mk(input string s);
        logic [255:0] f;
        f = {32{8'h20}};
        for (int i = 0; i < 32 && i < s.len(); i++) f[i*8 +: 8] = s[i];
        return f;
    endfunction

    function automatic logic [255:0] exp_frame(input logic [1:0] src);
        case (src)
            2'd0:    return f0;
            2'd1:    return f1;
            2'd2:    return f2;
            default: return blank;
        endcase
    endfunction

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic cyc(input logic [2:0] r, input logic fd);
        bus.req        = r;
        bus.frame_done = fd;
        step();
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(3'b000, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        f0     = mk("2024-05-06 12:30CLOCK PAGE");
        f1     = mk("SET MODE        HOUR: 12");
        f2     = mk("!! ALARM !!     07:00 WAKE UP");
        f2_alt = mk("!! ALARM !!     SNOOZE");
        blank  = {32{8'h20}};
        bus.frame0 = f0;
        bus.frame1 = f1;
        bus.frame2 = f2;
        bus.bl_in  = 1'b0;

        //        rst   req     fd    bl    grant   src   bl_out
        tv[0]  = '{1'b1, 3'b000, 1'b0, 1'b0, 3'b001, 2'd3, 1'b0};
        tv[1]  = '{1'b0, 3'b000, 1'b0, 1'b1, 3'b001, 2'd3, 1'b1};
        tv[2]  = '{1'b0, 3'b000, 1'b1, 1'b0, 3'b001, 2'd0, 1'b0};
        tv[3]  = '{1'b0, 3'b010, 1'b0, 1'b0, 3'b001, 2'd0, 1'b0};
        tv[4]  = '{1'b0, 3'b010, 1'b1, 1'b1, 3'b010, 2'd1, 1'b1};
        tv[5]  = '{1'b0, 3'b010, 1'b1, 1'b0, 3'b010, 2'd1, 1'b0};
        tv[6]  = '{1'b0, 3'b010, 1'b0, 1'b0, 3'b010, 2'd1, 1'b0};
        tv[7]  = '{1'b0, 3'b010, 1'b1, 1'b1, 3'b010, 2'd1, 1'b1};
        tv[8]  = '{1'b0, 3'b010, 1'b1, 1'b1, 3'b010, 2'd1, 1'b1};
        tv[9]  = '{1'b0, 3'b000, 1'b1, 1'b0, 3'b010, 2'd1, 1'b0};
        tv[10] = '{1'b0, 3'b000, 1'b1, 1'b0, 3'b010, 2'd1, 1'b0};
        tv[11] = '{1'b0, 3'b000, 1'b1, 1'b1, 3'b010, 2'd1, 1'b1};
        tv[12] = '{1'b0, 3'b000, 1'b1, 1'b0, 3'b010, 2'd1, 1'b0};
        tv[13] = '{1'b0, 3'b000, 1'b0, 1'b0, 3'b010, 2'd1, 1'b0};
        tv[14] = '{1'b0, 3'b000, 1'b1, 1'b1, 3'b001, 2'd0, 1'b1};
        tv[15] = '{1'b0, 3'b010, 1'b0, 1'b0, 3'b001, 2'd0, 1'b0};
        tv[16] = '{1'b0, 3'b100, 1'b0, 1'b1, 3'b001, 2'd0, 1'b1};
        tv[17] = '{1'b0, 3'b100, 1'b1, 1'b1, 3'b100, 2'd2, 1'b1};
        for (int i = 18; i <= 25; i++)
            tv[i] = '{1'b0, 3'b100, 1'b1, 1'b1, 3'b100, 2'd2, 1'b1};
        tv[26] = '{1'b0, 3'b010, 1'b0, 1'b1, 3'b100, 2'd2, 1'b1};
        tv[27] = '{1'b0, 3'b100, 1'b0, 1'b1, 3'b100, 2'd2, 1'b1};
        tv[28] = '{1'b0, 3'b100, 1'b1, 1'b1, 3'b100, 2'd2, 1'b1};
        tv[29] = '{1'b0, 3'b000, 1'b0, 1'b1, 3'b100, 2'd2, 1'b1};
        tv[30] = '{1'b0, 3'b000, 1'b1, 1'b1, 3'b001, 2'd0, 1'b1};

        for (int i = 0; i < NV; i++) begin
            rst            = tv[i].rst;
            bus.req        = tv[i].req;
            bus.frame_done = tv[i].fd;
            bus.bl_in      = tv[i].bl;
            step();
            chk($sformatf("vec%0d grant", i), 256'(bus.grant), 256'(tv[i].exp_grant));
            chk($sformatf("vec%0d data_out", i), bus.data_out, exp_frame(tv[i].exp_src));
            chk($sformatf("vec%0d bl_out", i), 256'(bus.bl_out), 256'(tv[i].exp_bl));
        end

        // Preempt owner 1 at dwell 2; alarm page then holds a full fresh dwell.
        do_reset();
        cyc(3'b010, 1'b0);
        cyc(3'b010, 1'b1);
        cyc(3'b010, 1'b1);
        cyc(3'b010, 1'b1);
        cyc(3'b110, 1'b0);
        chk("preempt no-load-on-entry grant", 256'(bus.grant), 256'(3'b010));
        cyc(3'b110, 1'b1);
        chk("preempt grant", 256'(bus.grant), 256'(3'b100));
        chk("preempt data", bus.data_out, f2);
        bus.frame2 = f2_alt;
        cyc(3'b000, 1'b0);
        chk("data stable between pulses", bus.data_out, f2);
        cyc(3'b000, 1'b1);
        chk("snapshot follows content", bus.data_out, f2_alt);
        for (int k = 0; k < 5; k++) cyc(3'b000, 1'b1);
        chk("dwell restarted grant@6", 256'(bus.grant), 256'(3'b100));
        cyc(3'b000, 1'b1);
        chk("dwell restarted grant@7", 256'(bus.grant), 256'(3'b100));
        cyc(3'b000, 1'b0);
        cyc(3'b000, 1'b1);
        chk("fallback grant", 256'(bus.grant), 256'(3'b001));
        chk("fallback data", bus.data_out, f0);
        bus.frame2 = f2;

        // Pulse coincident with a preempting request snapshots the old owner.
        do_reset();
        cyc(3'b010, 1'b0);
        cyc(3'b010, 1'b1);
        cyc(3'b100, 1'b1);
        chk("coincident grant", 256'(bus.grant), 256'(3'b010));
        chk("coincident data", bus.data_out, f1);
        cyc(3'b100, 1'b0);
        cyc(3'b100, 1'b1);
        chk("coincident next grant", 256'(bus.grant), 256'(3'b100));
        chk("coincident next data", bus.data_out, f2);

        // Pending request withdrawn before any pulse: switch cancelled.
        do_reset();
        cyc(3'b010, 1'b0);
        cyc(3'b000, 1'b0);
        cyc(3'b000, 1'b1);
        chk("cancel grant", 256'(bus.grant), 256'(3'b001));
        chk("cancel data", bus.data_out, f0);

        // Reset during a pending switch.
        do_reset();
        cyc(3'b100, 1'b0);
        rst = 1'b1;
        cyc(3'b000, 1'b0);
        chk("rst mid-swap grant", 256'(bus.grant), 256'(3'b001));
        chk("rst mid-swap data", bus.data_out, blank);
        chk("rst mid-swap bl_out", 256'(bus.bl_out), 256'(1'b0));
        rst = 1'b0;
        cyc(3'b000, 1'b1);
        chk("post-rst load grant", 256'(bus.grant), 256'(3'b001));
        chk("post-rst load data", bus.data_out, f0);

`ifdef LCD_ARB_BLINK_EN
        // Alarm-page backlight blink, 16 pulses per phase.
        do_reset();
        bus.bl_in = 1'b1;
        cyc(3'b100, 1'b0);
        cyc(3'b100, 1'b1);
        chk("blink entry", 256'(bus.bl_out), 256'(1'b1));
        for (int p = 1; p <= 32; p++) begin
            cyc(3'b100, 1'b1);
            chk($sformatf("blink pulse%0d", p), 256'(bus.bl_out),
                256'((p >= 16 && p < 32) ? 1'b0 : 1'b1));
        end
        rst = 1'b1;
        cyc(3'b100, 1'b0);
        rst = 1'b0;
        chk("blink rst bl_out", 256'(bus.bl_out), 256'(1'b0));
        chk("blink rst grant", 256'(bus.grant), 256'(3'b001));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_page_arbiter.md
LCD_PAGE_ARBITER -- requirements
Module: lcd_page_arbiter

Interface
REQ-001 SHALL have parameter DWELL_FRAMES, default 8: minimum frame_done pulses a granted page is held before a non-preempting switch.
REQ-002 SHALL have parameter BLINK_FRAMES, default 16: frame_done pulses per backlight toggle (REQ-026 only).
REQ-003 SHALL have port CLOCK_50  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  in  3  page requests; bit2 alarm (highest priority), bit1 set-mode, bit0 clock page.
REQ-006 SHALL have ports frame0, frame1, frame2  in  256 each  page content, 32 ASCII bytes, byte0 = line1 col1.
REQ-007 SHALL have port frame_done  in  1  one-cycle pulse from the LCD driver at end of a full refresh pass.
REQ-008 SHALL have port bl_in  in  1  requested backlight state.
REQ-009 SHALL have port data_out  out  256  frame to the LCD driver; changes only on frame_done cycles.
REQ-010 SHALL have port grant  out  3  one-hot current owner.
REQ-011 SHALL have port bl_out  out  1  backlight to the LCD driver.

Function
REQ-012 SHALL treat source 0 as always eligible; owner falls back to 0 when no other request is present.
REQ-013 SHALL implement the FSM states HOLD (dwell running), FREE (dwell expired), SWAP (switch pending).
REQ-014 HOLD: on each frame_done, dwell +1; on the frame_done where dwell reaches DWELL_FRAMES-1 -> FREE.
REQ-015 HOLD: a request with priority strictly above the owner -> SWAP next cycle, pending = highest requester (preemption).
REQ-016 FREE: if highest eligible source != owner -> SWAP next cycle, pending = that source; else stay FREE.
REQ-017 SWAP: pending re-evaluated every cycle; a higher request overrides pending; if pending's req drops, pending = highest eligible source; if that equals the owner -> back to FREE with no reload.
REQ-018 SWAP: on frame_done, owner <= pending, grant updated, data_out <= frame[pending], dwell <= 0 -> HOLD; the load never occurs in the same cycle SWAP is entered.
REQ-019 HOLD/FREE: on every frame_done, data_out <= frame[owner] (snapshot); data_out otherwise stable.
REQ-020 frame_done coincident with a new preempting request: the snapshot of the current owner is taken; the switch loads on the following frame_done.
REQ-021 The dwell counter SHALL saturate at DWELL_FRAMES-1 and never wrap; width = clog2(DWELL_FRAMES)+1.
REQ-022 grant SHALL be exactly one-hot in every cycle.
REQ-023 Without the feature of REQ-026, bl_out SHALL equal bl_in registered (1 cycle of latency).

Reset
REQ-024 While rst=1 at a clock edge: state FREE, owner 0, grant 3'b001, dwell 0, pending 0, data_out = 32 x 8'h20 (spaces), bl_out 0, blink counter 0.
REQ-025 rst mid-SWAP SHALL cancel the pending switch; the first frame_done after release loads frame0.

Configuration
REQ-026 With macro LCD_ARB_BLINK_EN defined: while owner = 2, bl_out toggles on every BLINK_FRAMES-th frame_done (counter cleared on entry to owner 2, bl_out starts 1); when owner != 2, bl_out = bl_in registered. Without the macro: no blink counter; REQ-023 applies unconditionally.

Verification
REQ-027 Reset, req=000, frame0 = "2024-05-06 12:30" pattern, frame_done pulse -> data_out = frame0, grant=001 one cycle after the pulse.
REQ-028 Owner 0, dwell expired, req=010 for 1 cycle then held -> SWAP, next frame_done loads frame1, grant=010; req dropped after 3 frames -> stays 010 until 8th frame_done, then loads frame0.
REQ-029 Owner 1 at dwell=2, req=110 -> preempt; next frame_done grant=100, data_out=frame2; dwell restarts at 0.
REQ-030 In SWAP, pending=1, req changes 010 -> 100 before frame_done -> loaded source is 2; pending dropped to 000 -> returns to FREE, no reload, grant unchanged.
REQ-031 frame_done and req=100 asserted in the same cycle -> that pulse snapshots the old owner; the next pulse loads frame2.
REQ-032 With LCD_ARB_BLINK_EN, owner 2, bl_in=1 -> bl_out 1 for 16 pulses, 0 for 16, 1 again; rst asserted mid-run -> bl_out=0, grant=001 next cycle.
